// File: rtl/seg_pkg.sv
// Shared opcode constants and FSM state type for the segment sequencer.
package seg_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MOVE  = 8'h01;
  localparam logic [7:0] OP_DWELL = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT_DONE,
    S_FAULT
  } seq_state_t;

endpackage

// File: rtl/segment_sequencer.sv
// Pops records from the record fifo, decodes the opcode and hands motion
// segments to the executor, with abort, sticky fault and record/underrun counters.
module segment_sequencer
  import seg_pkg::*;
#(
  parameter int WordSize    = 8,
  parameter int RecordWords = 16,
  parameter int CountWidth  = 16,
  localparam int RecordSizeBits = WordSize * RecordWords
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      abort,
  input  logic                      clear_error,
  input  logic                      fifo_empty,
  input  logic [RecordSizeBits-1:0] fifo_record,
  output logic                      fifo_read_en,
  output logic                      seg_valid,
  input  logic                      seg_ready,
  output logic [RecordSizeBits-1:0] seg_data,
  input  logic                      seg_done,
  output logic                      busy,
  output logic                      error,
  output logic [CountWidth-1:0]     record_count,
  output logic [CountWidth-1:0]     underrun_count
);

  seq_state_t                state_q;
  logic                      segValid_q;
  logic [RecordSizeBits-1:0] segData_q;
  logic                      error_q;
  logic [CountWidth-1:0]     recordCount_q;
  logic [CountWidth-1:0]     underrunCount_q;

  logic                      popAllowed;
  logic [7:0]                opcode;

  // A pop is only legal from IDLE or on the completing cycle of a segment.
  assign popAllowed   = enable && !fifo_empty && !abort && !error_q;
  assign fifo_read_en = popAllowed &&
                        ((state_q == S_IDLE) || ((state_q == S_WAIT_DONE) && seg_done));
  assign opcode       = segData_q[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      segValid_q      <= 1'b0;
      segData_q       <= '0;
      error_q         <= 1'b0;
      recordCount_q   <= '0;
      underrunCount_q <= '0;
    end else begin
      if (fifo_read_en) begin
        segData_q <= fifo_record;
      end
      unique case (state_q)
        S_IDLE: begin
          segValid_q <= 1'b0;
          if (fifo_read_en) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (opcode == OP_NOP) begin
            recordCount_q <= recordCount_q + CountWidth'(1);
            state_q       <= S_IDLE;
          end else if ((opcode == OP_MOVE) || (opcode == OP_DWELL)) begin
            segValid_q <= 1'b1;
            state_q    <= S_ISSUE;
          end else begin
            error_q <= 1'b1;
            state_q <= S_FAULT;
          end
        end
        S_ISSUE: begin
          // abort outranks a handshake landing in the same cycle
          if (abort) begin
            segValid_q <= 1'b0;
            state_q    <= S_IDLE;
          end else if (seg_ready) begin
            segValid_q <= 1'b0;
            state_q    <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (seg_done) begin
            recordCount_q <= recordCount_q + CountWidth'(1);
            if (fifo_read_en) begin
              state_q <= S_CHECK;
            end else begin
              if (enable && fifo_empty && (underrunCount_q != '1)) begin
                underrunCount_q <= underrunCount_q + CountWidth'(1);
              end
              state_q <= S_IDLE;
            end
          end
        end
        S_FAULT: begin
          segValid_q <= 1'b0;
          if (clear_error) begin
            error_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          segValid_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign seg_valid      = segValid_q;
  assign seg_data       = segData_q;
  assign busy           = (state_q != S_IDLE);
  assign error          = error_q;
  assign record_count   = recordCount_q;
  assign underrun_count = underrunCount_q;

endmodule

// File: tb/tb_segment_sequencer.sv
// Directed testbench for segment_sequencer with a small array-backed record fifo.
module tb_segment_sequencer;
  import seg_pkg::*;

  localparam int RecW = 128;
  localparam int CntW = 16;

  logic            clk = 1'b0;
  logic            rst, enable, abort, clear_error, seg_ready, seg_done;
  logic            fifo_empty, fifo_read_en, seg_valid, busy, error;
  logic [RecW-1:0] fifo_record, seg_data;
  logic [CntW-1:0] record_count, underrun_count;

  logic [RecW-1:0] fifoMem [16];
  int              fillCount = 0;
  int              popCount  = 0;
  int              popBase;
  int              passCount = 0;
  int              checkCount = 0;
  logic [RecW-1:0] expRec [3];
  logic [RecW-1:0] recA, recB;

  always #5 clk = ~clk;

  // Pops are tallied on the clock edge so the DUT samples the old head record.
  always @(posedge clk) if (fifo_read_en) popCount <= popCount + 1;
  assign fifo_empty  = (popCount == fillCount);
  assign fifo_record = fifoMem[popCount[3:0]];

  segment_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .abort(abort), .clear_error(clear_error),
    .fifo_empty(fifo_empty), .fifo_record(fifo_record), .fifo_read_en(fifo_read_en),
    .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_data(seg_data), .seg_done(seg_done),
    .busy(busy), .error(error), .record_count(record_count), .underrun_count(underrun_count)
  );

  function automatic logic [RecW-1:0] makeRecord(input logic [7:0] op, input logic [119:0] body);
    return {body, op};
  endfunction

  task automatic checkOutput(input string tag, input logic [RecW-1:0] obs, input logic [RecW-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [RecW-1:0] rec);
    fifoMem[fillCount[3:0]] = rec;
    fillCount++;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; abort = 1'b0; clear_error = 1'b0;
    seg_ready = 1'b0; seg_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    popBase = popCount;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset values
    resetDut();
    checkOutput("rst_read_en", fifo_read_en, 0);
    checkOutput("rst_valid", seg_valid, 0);
    checkOutput("rst_data", seg_data, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rcount", record_count, 0);
    checkOutput("rst_ucount", underrun_count, 0);

    // Single MOVE with an executor that is always ready
    recA = makeRecord(OP_MOVE, 120'h0123_4567_89ab_cdef_1122_3344_5566_77);
    applyStimulus(recA);
    enable = 1'b1;
    #1 checkOutput("t1_pop", fifo_read_en, 1);
    tick();
    checkOutput("t1_pop_pulse", fifo_read_en, 0);
    checkOutput("t1_check_valid", seg_valid, 0);
    checkOutput("t1_data", seg_data, recA);
    checkOutput("t1_busy", busy, 1);
    tick();
    checkOutput("t1_issue_valid", seg_valid, 1);
    seg_ready = 1'b1;
    tick();
    checkOutput("t1_wait_valid", seg_valid, 0);
    tick(4);
    checkOutput("t1_wait_busy", busy, 1);
    seg_done = 1'b1;
    tick();
    seg_done = 1'b0;
    checkOutput("t1_rcount", record_count, 1);
    checkOutput("t1_ucount", underrun_count, 1);
    checkOutput("t1_idle", busy, 0);
    checkOutput("t1_pops", popCount - popBase, 1);

    // Three MOVEs, back-to-back pops on seg_done
    resetDut();
    for (int i = 0; i < 3; i++) begin
      expRec[i] = makeRecord(OP_MOVE, 120'(32'hA000_0000 + i));
      applyStimulus(expRec[i]);
    end
    enable = 1'b1; seg_ready = 1'b1;
    #1 checkOutput("t2_first_pop", fifo_read_en, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t2_valid", seg_valid, 1);
      checkOutput("t2_data", seg_data, expRec[i]);
      tick();
      checkOutput("t2_hs_valid", seg_valid, 0);
      tick(2);
      seg_done = 1'b1;
      #1 checkOutput("t2_done_pop", fifo_read_en, (i < 2) ? 1 : 0);
      tick();
      seg_done = 1'b0;
    end
    checkOutput("t2_rcount", record_count, 3);
    checkOutput("t2_ucount", underrun_count, 1);
    checkOutput("t2_pops", popCount - popBase, 3);
    checkOutput("t2_idle", busy, 0);

    // Unknown opcode faults and blocks pops until cleared
    resetDut();
    recB = makeRecord(OP_DWELL, 120'h5a5a);
    applyStimulus(makeRecord(8'h7F, 120'hdead));
    applyStimulus(recB);
    enable = 1'b1;
    tick(2);
    checkOutput("t3_error", error, 1);
    checkOutput("t3_busy", busy, 1);
    #1 checkOutput("t3_no_pop", fifo_read_en, 0);
    tick(3);
    checkOutput("t3_pops_held", popCount - popBase, 1);
    checkOutput("t3_error_sticky", error, 1);
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    checkOutput("t3_cleared", error, 0);
    checkOutput("t3_cleared_idle", busy, 0);
    #1 checkOutput("t3_repop", fifo_read_en, 1);
    tick(2);
    checkOutput("t3_dwell_valid", seg_valid, 1);
    checkOutput("t3_dwell_data", seg_data, recB);
    seg_done = 1'b1;
    tick();
    seg_done = 1'b0;
    checkOutput("t3_done_ignored", seg_valid, 1);
    checkOutput("t3_rcount", record_count, 0);

    // abort together with seg_ready during ISSUE
    resetDut();
    applyStimulus(makeRecord(OP_MOVE, 120'h77));
    enable = 1'b1;
    tick(2);
    checkOutput("t4_valid", seg_valid, 1);
    seg_ready = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; seg_ready = 1'b0;
    checkOutput("t4_valid_drop", seg_valid, 0);
    checkOutput("t4_idle", busy, 0);
    checkOutput("t4_rcount", record_count, 0);
    tick();
    checkOutput("t4_still_idle", busy, 0);

    // NOP is consumed without a segment, then a MOVE issues normally
    resetDut();
    recA = makeRecord(OP_MOVE, 120'hbeef);
    applyStimulus(makeRecord(OP_NOP, 120'h1));
    applyStimulus(recA);
    enable = 1'b1;
    tick(2);
    checkOutput("t5_nop_count", record_count, 1);
    checkOutput("t5_nop_valid", seg_valid, 0);
    checkOutput("t5_nop_idle", busy, 0);
    #1 checkOutput("t5_pop_move", fifo_read_en, 1);
    tick(2);
    checkOutput("t5_move_valid", seg_valid, 1);
    checkOutput("t5_move_data", seg_data, recA);

    // enable dropped mid-segment: segment finishes, nothing more popped
    resetDut();
    applyStimulus(makeRecord(OP_MOVE, 120'h10));
    applyStimulus(makeRecord(OP_MOVE, 120'h20));
    enable = 1'b1; seg_ready = 1'b1;
    tick(3);
    enable = 1'b0;
    seg_done = 1'b1;
    #1 checkOutput("t6_no_pop", fifo_read_en, 0);
    tick();
    seg_done = 1'b0;
    checkOutput("t6_rcount", record_count, 1);
    checkOutput("t6_ucount", underrun_count, 0);
    checkOutput("t6_idle", busy, 0);
    tick();
    checkOutput("t6_pops", popCount - popBase, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/segment_sequencer.md
Name: segment_sequencer

Overview:
Controller between the record fifo and the motion segment executor. Pops one complete record when available, latches it, and decodes its opcode byte. It hands valid segments to the executor over a valid/ready handshake, waits for completion, then pops the next record. Also provides enable/abort control, a sticky fault on unknown opcodes, and executed-record and underrun counters.

Parameters:
WordSize, 8, bits per fifo word
RecordWords, 16, words per record; power of 2
CountWidth, 16, width of record_count and underrun_count
RecordSizeBits (derived), WordSize*RecordWords, record width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  allow popping new records
abort  in  1  kill the current segment and return to IDLE
clear_error  in  1  clear sticky fault
fifo_empty  in  1  fifo has no complete record
fifo_record  in  RecordSizeBits  fifo head record; word 0 in bits [WordSize-1:0]
fifo_read_en  out  1  pop strobe to fifo
seg_valid  out  1  segment offered to executor
seg_ready  in  1  executor accepts segment
seg_data  out  RecordSizeBits  latched record
seg_done  in  1  one-cycle pulse: executor finished segment
busy  out  1  state != IDLE
error  out  1  sticky fault flag
record_count  out  CountWidth  MOVE/DWELL records completed plus NOPs consumed; wraps
underrun_count  out  CountWidth  underruns; saturates at all-ones

Behaviour:
- Clock and reset: single clock clk; synchronous, active-high reset rst.
- Reset values: state IDLE; fifo_read_en=0, seg_valid=0, seg_data=0, error=0, both counters=0, busy=0.
- States: IDLE, CHECK, ISSUE, WAIT_DONE, FAULT.
- Pop rule: fifo_read_en is combinational. It is 1 only in IDLE, or in WAIT_DONE on a seg_done cycle, when enable && !fifo_empty && !abort && !error. In the same cycle, fifo_record is registered into seg_data. Pop-to-CHECK latency is 1 cycle. At most one pop per record.
- Opcodes, from seg_data[7:0]:
  - OP_NOP (0x00): record_count+1, then IDLE.
  - OP_MOVE (0x01) or OP_DWELL (0x02): go to ISSUE.
  - Any other value: go to FAULT and set error=1.
- ISSUE: seg_valid=1, seg_data stable until the handshake. Handshake completes on the cycle where seg_valid && seg_ready; next state WAIT_DONE with seg_valid=0. seg_done seen in ISSUE is ignored.
- WAIT_DONE: on seg_done, record_count+1, then:
  - If the pop rule holds: back-to-back pop, go to CHECK.
  - Else if enable && fifo_empty: underrun_count+1 (saturating), go to IDLE.
  - Else: go to IDLE.
- Disabling: enable=0 never cancels an in-flight segment. It only blocks new pops.
- abort: from CHECK, ISSUE or WAIT_DONE, go to IDLE next cycle. seg_valid drops, no pop, no count change. abort wins over a simultaneous seg_ready or seg_done. abort has no effect in IDLE and FAULT.
- FAULT: no pops, seg_valid=0. clear_error=1 clears error and returns to IDLE next cycle. rst also clears it.
- Counter widths: record_count wraps modulo 2^CountWidth; underrun_count saturates.
- Reset mid-segment: all state is discarded. The fifo is not flushed by this block.

Decomposition:
- Package seg_pkg: opcode constants OP_NOP, OP_MOVE, OP_DWELL; enum seq_state_t for the FSM states.
- Single module, no sub-modules. A saturating counter is inlined and not split out.

Test Plan:
- Reset, then enable=1 with one MOVE record in the fifo: fifo_read_en pulses 1 cycle; seg_valid rises 2 cycles after the pop. With seg_ready held 1, seg_done pulsed 5 cycles later: record_count=1, underrun_count=1, back in IDLE.
- Three MOVE records, executor ready immediately, done after 3 cycles: three pops, each pop in the same cycle as the previous seg_done; record_count=3; final underrun_count=1.
- Record with opcode 0x7F: error=1, state FAULT, no further pops while the fifo is non-empty. Then clear_error: IDLE next cycle, next record popped.
- abort asserted in the same cycle as seg_ready during ISSUE: seg_valid=0 next cycle, state IDLE, record_count unchanged.
- NOP, then MOVE: record_count=1 after the NOP with no seg_valid; the MOVE is then issued normally.
- enable dropped during WAIT_DONE with the fifo non-empty: segment completes, no pop, underrun_count unchanged, state IDLE.
